// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary MAC array.
// It clears the accumulators and then drives skewed feed enables and addresses
// so PE(i,j) sees operand pair t at FEED count i + j + t. It then steps a row
// selector over the finished accumulators and pulses done.
// Every output is a flop loaded from the next-state decode. No input reaches an
// output combinationally.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int AW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   k_len,
  output logic            clear,
  output logic [N-1:0]    feed_en,
  output logic [N*AW-1:0] feed_addr,
  output logic            rd_valid,
  output logic [RW-1:0]   rd_row,
  output logic            busy,
  output logic            done
);

  // FEED counter wide enough for k_len + 2N - 2 with headroom, so it never wraps
  localparam int CW = AW + $clog2(2 * N) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, READ, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   f_q, f_n;
  logic [RW-1:0]   rd_q, rd_n;
  logic [AW-1:0]   k_q;
  logic            k_load;
  logic [CW-1:0]   k_ext;
  logic [CW-1:0]   f_end;
  logic [N-1:0]    en_n;
  logic [N*AW-1:0] addr_n;

  assign k_ext = {{(CW - AW){1'b0}}, k_q};
  assign f_end = k_ext + CW'(2 * N - 2);

  // Next-state and counter decode; abort cancels any active state, start only counts in IDLE
  always_comb begin
    state_n = state;
    f_n     = f_q;
    rd_n    = rd_q;
    k_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          k_load  = 1'b1;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_n = IDLE;
        end else if (k_q == '0) begin
          state_n = READ;
          rd_n    = '0;
        end else begin
          state_n = FEED;
          f_n     = '0;
        end
      end
      FEED: begin
        if (abort) begin
          state_n = IDLE;
        end else if (f_q + CW'(1) == f_end) begin
          state_n = READ;
          rd_n    = '0;
        end else begin
          f_n = f_q + CW'(1);
        end
      end
      READ: begin
        if (abort) begin
          state_n = IDLE;
        end else if (rd_q == RW'(N - 1)) begin
          state_n = DONE;
        end else begin
          rd_n = rd_q + RW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Skew decode for the upcoming cycle: feed i is live for i <= f < i + k_len
  always_comb begin
    en_n   = '0;
    addr_n = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_n == FEED) && (f_n >= CW'(i)) && (f_n < CW'(i) + k_ext)) begin
        en_n[i]              = 1'b1;
        addr_n[i*AW +: AW]   = AW'(f_n - CW'(i));
      end
    end
  end

  // Latch the inner-dimension length when a run is accepted
  always_ff @(posedge clk) begin
    if (k_load) begin
      k_q <= k_len;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f_q       <= '0;
      rd_q      <= '0;
      clear     <= 1'b0;
      feed_en   <= '0;
      feed_addr <= '0;
      rd_valid  <= 1'b0;
      rd_row    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      f_q       <= f_n;
      rd_q      <= rd_n;
      clear     <= (state_n == CLEAR);
      feed_en   <= en_n;
      feed_addr <= addr_n;
      rd_valid  <= (state_n == READ);
      rd_row    <= (state_n == READ) ? rd_n : '0;
      busy      <= (state_n == CLEAR) || (state_n == FEED) || (state_n == READ);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a behavioural 4x4 output-stationary
// PE array. The array is fed A = all 1s on the rows and B = all 2s on the columns.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam logic [7:0] A_VAL = 8'd1;
  localparam logic [7:0] B_VAL = 8'd2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [AW-1:0]   k_len;
  logic            clear;
  logic [N-1:0]    feed_en;
  logic [N*AW-1:0] feed_addr;
  logic            rd_valid;
  logic [1:0]      rd_row;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  systolic_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .clear(clear), .feed_en(feed_en), .feed_addr(feed_addr),
    .rd_valid(rd_valid), .rd_row(rd_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: rows flow right, columns flow down, zero when a feed is idle
  logic [7:0]  a_pipe [N][N];
  logic [7:0]  b_pipe [N][N];
  logic [15:0] acc    [N][N];

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return feed_en[i] ? A_VAL : 8'd0;
    return a_pipe[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return feed_en[j] ? B_VAL : 8'd0;
    return b_pipe[i-1][j];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= a_in(i, j);
          b_pipe[i][j] <= b_in(i, j);
          acc[i][j]    <= clear ? 16'd0 : acc[i][j] + 16'(a_in(i, j)) * 16'(b_in(i, j));
        end
    end
  end

  // Hand-computed feed pattern for N=4, k_len=3, indexed by cycle 0..16
  logic [3:0]  exp_en   [17] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [31:0] exp_addr [17] = '{32'h0, 32'h0, 32'h0000_0000, 32'h0000_0001,
                                 32'h0000_0102, 32'h0001_0200, 32'h0102_0000,
                                 32'h0200_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({clear, feed_en, feed_addr, rd_valid, rd_row, busy, done});
  endfunction

  // One full run from IDLE; returns in the cycle after DONE (block idle again)
  task automatic run_case(input string tag, input int k, input int exp_acc,
                          input int exp_first_rd, input int exp_done, input logic exp_any_en);
    int   cyc;
    int   first_rd;
    int   nrd;
    int   done_cyc;
    logic got;
    logic any_en;
    k_len = AW'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; first_rd = -1; nrd = 0; done_cyc = -1; got = 1'b0; any_en = 1'b0;
    check({tag, ".clear"}, 64'(clear), 64'd1);
    while (!got && cyc < 60) begin
      if (feed_en != '0) any_en = 1'b1;
      if (rd_valid) begin
        if (first_rd < 0) first_rd = cyc;
        nrd++;
        for (int j = 0; j < N; j++)
          check($sformatf("%s.acc[%0d][%0d]", tag, rd_row, j), 64'(acc[rd_row][j]), 64'(exp_acc));
      end
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
      end else begin
        step();
        cyc++;
      end
    end
    check({tag, ".done_seen"}, 64'(got), 64'd1);
    check({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, ".first_rd"}, 64'(first_rd), 64'(exp_first_rd));
    check({tag, ".rd_cycles"}, 64'(nrd), 64'd4);
    check({tag, ".any_feed_en"}, 64'(any_en), 64'(exp_any_en));
    step();
    check({tag, ".idle_after"}, all_out(), 64'd0);
  endtask

  initial begin
    int ndone;
    int nd_abort;
    rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
    #1;
    check("reset.outputs", all_out(), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("idle.outputs", all_out(), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle.abort_no_effect", all_out(), 64'd0);

    // Basic run, k_len=3: F=9, FEED 2..10, READ 11..14, DONE 15
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start = 1'b0;
      check($sformatf("basic.clear c%0d", c), 64'(clear), 64'(c == 1));
      check($sformatf("basic.feed_en c%0d", c), 64'(feed_en), 64'(exp_en[c]));
      check($sformatf("basic.feed_addr c%0d", c), 64'(feed_addr), 64'(exp_addr[c]));
      check($sformatf("basic.busy c%0d", c), 64'(busy), 64'(c >= 1 && c <= 14));
      check($sformatf("basic.rd_valid c%0d", c), 64'(rd_valid), 64'(c >= 11 && c <= 14));
      check($sformatf("basic.rd_row c%0d", c), 64'(rd_row),
            (c >= 11 && c <= 14) ? 64'(c - 11) : 64'd0);
      check($sformatf("basic.done c%0d", c), 64'(done), 64'(c == 15));
    end

    // End-to-end: 5 pairs of 1*2 per PE, twice back to back
    run_case("e2e1", 5, 10, 13, 17, 1'b1);
    run_case("e2e2", 5, 10, 13, 17, 1'b1);

    // Zero length: FEED skipped, READ 2..5, DONE 6
    run_case("zero", 0, 0, 2, 6, 1'b0);

    // Start pulses during FEED and in the DONE cycle are ignored
    k_len = 8'd3;
    start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 17; c++) begin
      step();
      start = 1'b0;
      if (done) ndone++;
      if (c == 4) start = 1'b1;
      if (c == 5) check("busy_start.clear_c5", 64'(clear), 64'd0);
      if (c == 5) check("busy_start.feed_en_c5", 64'(feed_en), 64'hE);
      if (c == 15) begin
        check("busy_start.done_c15", 64'(done), 64'd1);
        start = 1'b1;
      end
      if (c == 16) begin
        check("busy_start.idle_c16", all_out(), 64'd0);
        start = 1'b1;
      end
      if (c == 17) check("busy_start.restart_clear", 64'(clear), 64'd1);
    end
    check("busy_start.done_count", 64'(ndone), 64'd1);
    begin
      int   t;
      logic seen;
      t = 0; seen = 1'b0;
      while (!seen && t < 60) begin
        step();
        t++;
        if (done) seen = 1'b1;
      end
      check("busy_start.restart_done", 64'(seen), 64'd1);
      check("busy_start.restart_latency", 64'(t + 1), 64'd15);
      step();
    end

    // Abort at f=4 (cycle 6)
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    check("abort.feed_en_f4", 64'(feed_en), 64'hC);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.idle_next", all_out(), 64'd0);
    nd_abort = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done || busy) nd_abort++;
    end
    check("abort.no_activity", 64'(nd_abort), 64'd0);
    run_case("after_abort", 3, 6, 11, 15, 1'b1);

    // Asynchronous reset between edges during READ
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
    end
    check("arst.in_read", 64'(rd_valid), 64'd1);
    check("arst.rd_row", 64'(rd_row), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.immediate", all_out(), 64'd0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("arst.stays_idle %0d", c), all_out(), 64'd0);
    end
    run_case("after_rst", 5, 10, 13, 17, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for an N x N output-stationary array of 8-bit multiply-accumulate PEs. On a start request it clears the PE accumulators, then drives skewed read addresses and enables into the row-data and column-weight buffers so PE(i,j) sees its operand pairs in order. It then steps a row selector across the finished accumulators for readout and reports completion. It sits between the host-side buffer/command logic and the PE array.

## Interface

- N, 4: array dimension; there are N row feeds and N column feeds.
- AW, 8: width of the inner-dimension length and of each feed address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any non-IDLE state.
- k_len  in  AW  inner-dimension length (number of operand pairs per PE); latched when start is accepted.
- clear  out  1  accumulator clear, wired to every PE's clear input.
- feed_en  out  N  bit i: row i data and column i weight are valid this cycle.
- feed_addr  out  N*AW  slice i (bits i*AW +: AW): buffer read index for row i and column i.
- rd_valid  out  1  rd_row is valid; the selected row of accumulators is stable.
- rd_row  out  clog2(N)  accumulator row being read out.
- busy  out  1  high in CLEAR, FEED and READ.
- done  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, CLEAR, FEED, READ, DONE.
- **IDLE**
  - All outputs are 0.
  - start=1 latches k_len and moves to CLEAR.
- **CLEAR**
  - Lasts 1 cycle with clear=1, then moves to FEED.
  - If k_len=0, it goes to READ instead and FEED is skipped; the results are all zero.
- **FEED**
  - Lasts F = k_len + 2N - 2 cycles, counted by f = 0..F-1.
  - feed_en[i] = 1 exactly when i <= f < i + k_len.
  - Slice i of feed_addr = f - i when enabled, otherwise 0.
  - The internal counter is at least AW+clog2(2N)+1 bits wide and never wraps.
  - When feed_en[i]=0, the external mux drives 0 into row i and column i. Adding 0 leaves the accumulators unchanged, so the array needs no enable.
- **READ**
  - Lasts N cycles with rd_valid=1 and rd_row = 0..N-1 in order.
  - feed_en stays 0, so the accumulators hold their values.
- **DONE**
  - Lasts 1 cycle with done=1 and busy=0, then returns to IDLE.
- **abort**
  - abort=1 in CLEAR, FEED, READ or DONE moves to IDLE on the next edge.
  - From the next cycle, feed_en=0, rd_valid=0, and done is not pulsed.
  - abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- **start while not in IDLE** is ignored and is not queued. This includes the DONE cycle.
- **rst** during any state forces IDLE immediately and drives all outputs to 0. The PE accumulators are reset by the same rst.

## Timing

- Reset value of every output is 0: clear, feed_en, feed_addr, rd_valid, rd_row, busy, done.
- All outputs are registered, decoded from state and counter flops, with no combinational path from inputs.
- Counting cycle 0 as the cycle where start=1 is sampled in IDLE:
  - cycle 1 is CLEAR;
  - cycles 2..F+1 are FEED;
  - cycles F+2..F+N+1 are READ;
  - cycle F+N+2 is DONE.
- Start-to-done latency = k_len + 3N.
- With k_len=0, FEED is skipped and DONE falls at cycle N+2.
- The last operand pair reaches PE(N-1,N-1) at FEED count f = k_len + 2N - 3. Its accumulator is updated at the end of that cycle, so it is stable in the first READ cycle.
- A new start is accepted at the earliest in the cycle after DONE, when the block is back in IDLE.

## Test plan

- **Basic run.** Reset, then N=4, k_len=3, start at cycle 0.
  - clear=1 only at cycle 1.
  - FEED covers cycles 2..10.
  - feed_en[0] is high at f=0..2; feed_en[3] is high at f=3..5.
  - feed_addr slice 3 counts 0,1,2 over f=3..5.
  - rd_row counts 0..3 over cycles 11..14.
  - done=1 at cycle 15 only; busy=1 over cycles 1..14.
- **End-to-end with PE array.** Use A = all 1s and B = all 2s with k_len=5.
  - Every PE output is 10 when rd_valid=1.
  - A second back-to-back run gives 10 again, not 20, which proves clear works.
- **Zero length.** k_len=0.
  - feed_en is never set.
  - READ covers cycles 2..5 and done=1 at cycle 6.
  - All accumulators read 0.
- **Start while busy.** Pulse start during FEED and again in the DONE cycle.
  - Neither pulse starts a run; only one done pulse occurs.
  - start at the cycle after DONE begins a new run.
- **Abort.** abort during FEED at f=4.
  - The next cycle shows IDLE with all outputs 0 and no done pulse.
  - A subsequent start runs normally.
- **Async reset mid-READ.** Assert rst between clock edges.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, the block stays idle until start.
